signed_pow2_divide_sequencer: RTL
=================================

SIGNED_POW2_DIVIDE_SEQUENCER -- requirements
Module: signed_pow2_divide_sequencer

Interface
REQ-001 SHALL have parameter N, default 8, operand and result width in bits.
REQ-002 SHALL have parameter SW, default 3, shift-amount width in bits.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 SHALL have port in_a, input, N, signed dividend (two's complement).
REQ-008 SHALL have port in_s, input, SW, unsigned shift amount S (divisor 2**S).
REQ-009 SHALL have port out_valid, output, 1, result present.
REQ-010 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-011 SHALL have port out_res, output, N, signed quotient.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-014 IDLE with in_valid=1: on the edge, SHALL latch in_a into accumulator acc, load counter cnt = in_s, clear sticky bit, and go to SHIFT if in_s != 0, else to DONE.
REQ-015 SHIFT, each edge: acc <= {acc[N-1], acc[N-1:1]}, sticky <= sticky | acc[0], cnt <= cnt - 1; go to DONE on the edge where cnt == 1.
REQ-016 Latency SHALL be in_s + 1 edges from the accept edge to out_valid visible (S=0: 1 edge; S=7: 8 edges).
REQ-017 S >= N SHALL be legal; the shift continues to all-sign-bits (0 or -1 floor result); cnt does not wrap.
REQ-018 DONE: out_res and out_valid SHALL hold stable while out_ready=0; on out_valid & out_ready, go to IDLE on that edge.
REQ-019 in_valid SHALL be ignored outside IDLE; a new request is not accepted in the handshake cycle of DONE (first accept possible one edge later).
REQ-020 in_a and in_s SHALL be sampled only on the accept edge; later changes have no effect on the result in progress.
REQ-021 Outside DONE, out_res SHALL equal the current acc value (don't-care to the consumer, but deterministic).

Reset
REQ-022 rst=1 on an edge SHALL force state IDLE, acc=0, cnt=0, sticky=0; out_valid=0, busy=0, in_ready=1, out_res=0 on the next cycle.
REQ-023 rst SHALL take priority over any handshake in the same cycle; an operation in SHIFT or DONE is discarded with no output.

Configuration
REQ-024 Macro ROUND_TO_ZERO_EN defined: out_res SHALL equal acc + (acc[N-1] & sticky), i.e. signed division truncated toward zero (C semantics a / 2**S).
REQ-025 Macro ROUND_TO_ZERO_EN undefined: out_res SHALL equal acc, i.e. arithmetic shift a >>> S (rounds toward minus infinity); the sticky register may be omitted.

Verification (N=8, SW=3)
REQ-026 a=-13 (8'hF3), S=2, out_ready=1 -> out_valid after 3 edges; out_res=-4 (8'hFC) without macro, -3 (8'hFD) with ROUND_TO_ZERO_EN.
REQ-027 a=100, S=3 -> out_res=12 both builds, latency 4 edges; a=-1, S=0 -> out_res=-1, latency 1 edge.
REQ-028 a=-1, S=7 -> out_res=-1 without macro, 0 with macro; a=-128, S=7 -> -1 in both builds.
REQ-029 a=-13, S=2, out_ready held 0 for 5 cycles -> out_res and out_valid stable, in_ready=0 and new in_valid ignored; one edge after out_ready=1, in_ready=1.
REQ-030 rst=1 asserted in second SHIFT cycle of a=100, S=5 -> next cycle state IDLE, out_valid=0, busy=0; a following a=64, S=1 request returns 32.

Source files
------------

// File: rtl/signed_pow2_divide_sequencer.sv
// Sequential signed divide by 2**S: one arithmetic right shift per clock, with a valid/ready handshake.
// Defining ROUND_TO_ZERO_EN truncates toward zero; otherwise the result rounds toward minus infinity.
module signed_pow2_divide_sequencer #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [SW-1:0] in_s,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_res,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_reg;
  logic [N-1:0]  acc_reg;
  logic [SW-1:0] cnt_reg;
  logic          in_ready_reg;
  logic          out_valid_reg;
  logic          busy_reg;
`ifdef ROUND_TO_ZERO_EN
  logic          sticky_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
`ifdef ROUND_TO_ZERO_EN
      sticky_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            acc_reg      <= in_a;
            cnt_reg      <= in_s;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
`ifdef ROUND_TO_ZERO_EN
            sticky_reg   <= 1'b0;
`endif
            if (in_s != '0) begin
              state_reg <= SHIFT;
            end else begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
            end
          end
        end
        SHIFT: begin
          // Counter stops at zero on the transition to DONE, so large S never wraps.
          acc_reg <= {acc_reg[N-1], acc_reg[N-1:1]};
          cnt_reg <= cnt_reg - 1'b1;
`ifdef ROUND_TO_ZERO_EN
          sticky_reg <= sticky_reg | acc_reg[0];
`endif
          if (cnt_reg == SW'(1)) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;

`ifdef ROUND_TO_ZERO_EN
  // A negative result that lost any one-bits is one too small for truncation toward zero.
  assign out_res = acc_reg + {{(N-1){1'b0}}, acc_reg[N-1] & sticky_reg};
`else
  assign out_res = acc_reg;
`endif

endmodule
